// File: rtl/fetch_stage.sv
// IF stage: fetches at R15 over a req/ready handshake, computes the next PC and
// loads the IF/ID latch, with a one-entry skid buffer absorbing ID stalls.
module fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'hE1A00000,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clock,
  input  logic        R,
  input  logic [31:0] PCout,
  output logic [31:0] PCin,
  output logic        PCE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] PC_4_out
);

  typedef enum logic [1:0] {
    S_RST,
    S_FETCH,
    S_FLUSH,
    S_HOLD
  } state_t;

  state_t      state, state_nx;

  logic [31:0] ifid_instr, ifid_instr_nx;
  logic [31:0] ifid_pc4, ifid_pc4_nx;
  logic        ifid_valid, ifid_valid_nx;
  logic [31:0] skid_instr, skid_instr_nx;
  logic [31:0] skid_pc4, skid_pc4_nx;
  logic [31:0] pend, pend_nx;
  logic [31:0] pc_seq;

  assign pc_seq      = PCout + PC_STEP;
  assign imem_addr   = PCout;
  assign instr_out   = ifid_valid ? ifid_instr : NOP_INSTR;
  assign instr_valid = ifid_valid;
  assign PC_4_out    = ifid_pc4;

  always_ff @(posedge clock or posedge R) begin
    if (R) begin
      state      <= S_RST;
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc4   <= '0;
      pend       <= '0;
    end else begin
      state      <= state_nx;
      ifid_instr <= ifid_instr_nx;
      ifid_pc4   <= ifid_pc4_nx;
      ifid_valid <= ifid_valid_nx;
      skid_instr <= skid_instr_nx;
      skid_pc4   <= skid_pc4_nx;
      pend       <= pend_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    ifid_instr_nx = ifid_instr;
    ifid_pc4_nx   = ifid_pc4;
    ifid_valid_nx = ifid_valid;
    skid_instr_nx = skid_instr;
    skid_pc4_nx   = skid_pc4;
    pend_nx       = pend;
    imem_req      = 1'b0;
    PCE           = 1'b0;
    PCin          = pc_seq;

    case (state)
      // One idle cycle after reset so a response to a pre-reset request is ignored.
      S_RST: state_nx = S_FETCH;

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          PCE = 1'b1;
          if (br_taken) begin
            PCin          = br_target;
            ifid_valid_nx = 1'b0;
          end else if (!ifid_valid || !stall) begin
            ifid_instr_nx = imem_data;
            ifid_pc4_nx   = pc_seq;
            ifid_valid_nx = 1'b1;
          end else begin
            skid_instr_nx = imem_data;
            skid_pc4_nx   = pc_seq;
            state_nx      = S_HOLD;
          end
        end else if (br_taken) begin
          // Request cannot be withdrawn: remember the target, drain the old fetch.
          pend_nx       = br_target;
          ifid_valid_nx = 1'b0;
          state_nx      = S_FLUSH;
        end else if (!stall) begin
          ifid_valid_nx = 1'b0;
        end
      end

      S_FLUSH: begin
        imem_req      = 1'b1;
        ifid_valid_nx = 1'b0;
        if (imem_ready) begin
          PCE      = 1'b1;
          PCin     = br_taken ? br_target : pend;
          state_nx = S_FETCH;
        end else if (br_taken) begin
          pend_nx = br_target;
        end
      end

      S_HOLD: begin
        if (br_taken) begin
          PCE           = 1'b1;
          PCin          = br_target;
          ifid_valid_nx = 1'b0;
          state_nx      = S_FETCH;
        end else if (!stall) begin
          ifid_instr_nx = skid_instr;
          ifid_pc4_nx   = skid_pc4;
          ifid_valid_nx = 1'b1;
          state_nx      = S_FETCH;
        end
      end

      default: state_nx = S_RST;
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: acts as register file R15 and instruction memory, and
// predicts outputs with a queue model of the IF/ID latch plus skid buffer.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clock = 1'b0;
  logic        R = 1'b0;
  logic [31:0] PCout = '0;
  logic [31:0] PCin;
  logic        PCE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_data = '0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] PC_4_out;

  int unsigned errors = 0;
  int unsigned checks = 0;

  fetch_stage #(.NOP_INSTR(NOP), .PC_STEP(32'd4)) dut (
    .clock      (clock),
    .R          (R),
    .PCout      (PCout),
    .PCin       (PCin),
    .PCE        (PCE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_data  (imem_data),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .PC_4_out   (PC_4_out)
  );

  always #5 clock = ~clock;

  // Reference model: words delivered to ID form a FIFO of depth 2 (latch + skid).
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc4;
  } ent_t;

  ent_t        q[$];
  bit          in_rst = 1'b1;
  bit          cool = 1'b1;
  bit          pend_v = 1'b0;
  logic [31:0] pend = '0;
  logic [31:0] pc = '0;

  logic        exp_req, exp_pce, exp_valid;
  logic [31:0] exp_pcin, exp_instr, exp_pc4;
  logic [98:0] exp_bus;
  logic [98:0] obs_bus;

  assign obs_bus = {imem_req, imem_addr, PCE, PCin, instr_valid, instr_out};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'hE2811001;
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  task automatic eval();
    bit act;
    act      = !in_rst && !cool;
    exp_req  = act && (q.size() < 2);
    exp_pce  = 1'b0;
    exp_pcin = pc + 32'd4;
    if (act) begin
      if (q.size() < 2) begin
        if (imem_ready) begin
          exp_pce  = 1'b1;
          exp_pcin = br_taken ? br_target : (pend_v ? pend : pc + 32'd4);
        end
      end else if (br_taken) begin
        exp_pce  = 1'b1;
        exp_pcin = br_target;
      end
    end
    exp_valid = q.size() > 0;
    exp_instr = NOP;
    exp_pc4   = '0;
    if (exp_valid) begin
      exp_instr = q[0].data;
      exp_pc4   = q[0].pc4;
    end
    exp_bus = {exp_req, pc, exp_pce, exp_pcin, exp_valid, exp_instr};
  endtask

  task automatic update();
    ent_t e;
    if (in_rst) return;
    if (cool) begin
      cool = 1'b0;
      return;
    end
    if (br_taken) begin
      q.delete();
      if (exp_req && !imem_ready) begin
        pend_v = 1'b1;
        pend   = br_target;
      end else if (exp_req) begin
        pend_v = 1'b0;
      end
    end else begin
      if (!stall && q.size() > 0) void'(q.pop_front());
      if (exp_req && imem_ready) begin
        if (pend_v) pend_v = 1'b0;
        else begin
          e.data = mem_word(pc);
          e.pc4  = pc + 32'd4;
          q.push_back(e);
        end
      end
    end
    if (exp_pce) pc = exp_pcin;
  endtask

  task automatic model_reset();
    q.delete();
    pend_v = 1'b0;
    cool   = 1'b1;
    in_rst = 1'b1;
  endtask

  task automatic drive(input bit rdy, input bit st, input bit br, input logic [31:0] tgt);
    imem_ready = rdy;
    stall      = st;
    br_taken   = br;
    br_target  = tgt;
    PCout      = pc;
    imem_data  = mem_word(pc);
    #1;
    eval();
  endtask

  task automatic tick();
    @(posedge clock);
    update();
    @(negedge clock);
  endtask

  task automatic do_reset(input logic [31:0] start);
    R = 1'b1;
    imem_ready = 1'b0;
    stall = 1'b0;
    br_taken = 1'b0;
    #1;
    model_reset();
    pc = start;
    PCout = start;
    @(negedge clock);
    R = 1'b0;
    in_rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 R = 1'b1;
    #1;
    checks++;
    if ({imem_req, PCE, instr_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got req/pce/valid=%b exp=000", {imem_req, PCE, instr_valid});
    end
    checks++;
    if ({instr_out, PC_4_out} !== {NOP, 32'h0}) begin
      errors++;
      $display("FAIL reset_ifid got instr=%h pc4=%h exp instr=%h pc4=0", instr_out, PC_4_out, NOP);
    end
    @(negedge clock);
    R = 1'b0;
    in_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (obs_bus !== exp_bus) begin
        errors++;
        $display("FAIL reset_run cyc=%0d got=%h exp=%h", i, obs_bus, exp_bus);
      end
      if (i == 0) begin
        checks++;
        if (imem_req !== 1'b0) begin
          errors++;
          $display("FAIL rst_idle_req got=%b exp=0", imem_req);
        end
      end else begin
        checks++;
        if (PCE !== 1'b1 || PCin !== 32'(4 * i)) begin
          errors++;
          $display("FAIL seq_pcin cyc=%0d got pce=%b pcin=%h exp pce=1 pcin=%h", i, PCE, PCin, 32'(4 * i));
        end
      end
      if (i >= 2) begin
        checks++;
        if (instr_valid !== 1'b1 || PC_4_out !== 32'(4 * (i - 1))) begin
          errors++;
          $display("FAIL seq_valid cyc=%0d got v=%b pc4=%h exp v=1 pc4=%h", i, instr_valid, PC_4_out, 32'(4 * (i - 1)));
        end
      end
      tick();
    end
  endtask

  task automatic test_wait();
    logic [31:0] a0;
    a0 = pc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (obs_bus !== exp_bus) begin
        errors++;
        $display("FAIL wait_bus cyc=%0d got=%h exp=%h", i, obs_bus, exp_bus);
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== a0 || PCE !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold cyc=%0d got req=%b addr=%h pce=%b exp 1 %h 0", i, imem_req, imem_addr, PCE, a0);
      end
      if (i > 0) begin
        checks++;
        if (instr_valid !== 1'b0 || instr_out !== NOP) begin
          errors++;
          $display("FAIL wait_bubble cyc=%0d got v=%b instr=%h exp v=0 instr=%h", i, instr_valid, instr_out, NOP);
        end
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (PCE !== 1'b1 || PCin !== a0 + 32'd4) begin
      errors++;
      $display("FAIL wait_ready got pce=%b pcin=%h exp 1 %h", PCE, PCin, a0 + 32'd4);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== mem_word(a0)) begin
      errors++;
      $display("FAIL wait_data got v=%b instr=%h exp 1 %h", instr_valid, instr_out, mem_word(a0));
    end
    tick();
  endtask

  task automatic test_stall_hold();
    do_reset(32'h3C);
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 1'b1, 1'b0, '0);
    checks++;
    if (obs_bus !== exp_bus) begin
      errors++;
      $display("FAIL stall_accept got=%h exp=%h", obs_bus, exp_bus);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(i == 1, i != 2, 1'b0, '0);
      checks++;
      if (imem_req !== 1'b0 || instr_out !== mem_word(32'h3C) || PC_4_out !== 32'h40 || PCE !== 1'b0) begin
        errors++;
        $display("FAIL hold_ifid cyc=%0d got req=%b instr=%h pc4=%h pce=%b exp 0 %h 00000040 0",
                 i, imem_req, instr_out, PC_4_out, PCE, mem_word(32'h3C));
      end
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== 32'hE2811001 || PC_4_out !== 32'h44) begin
      errors++;
      $display("FAIL skid_release got v=%b instr=%h pc4=%h exp 1 e2811001 00000044", instr_valid, instr_out, PC_4_out);
    end
    checks++;
    if (obs_bus !== exp_bus) begin
      errors++;
      $display("FAIL skid_bus got=%h exp=%h", obs_bus, exp_bus);
    end
    tick();
  endtask

  task automatic test_branch_wait();
    logic [31:0] a0;
    a0 = pc;
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    checks++;
    if (PCE !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL br_wait got pce=%b req=%b exp 0 1", PCE, imem_req);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== a0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_keep got req=%b addr=%h v=%b exp 1 %h 0", imem_req, imem_addr, instr_valid, a0);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (PCE !== 1'b1 || PCin !== 32'h100) begin
      errors++;
      $display("FAIL flush_redirect got pce=%b pcin=%h exp 1 00000100", PCE, PCin);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (imem_addr !== 32'h100 || instr_valid !== 1'b0 || obs_bus !== exp_bus) begin
      errors++;
      $display("FAIL flush_nowrong got addr=%h v=%b bus=%h exp addr=00000100 v=0 bus=%h", imem_addr, instr_valid, obs_bus, exp_bus);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== mem_word(32'h100)) begin
      errors++;
      $display("FAIL flush_target got v=%b instr=%h exp 1 %h", instr_valid, instr_out, mem_word(32'h100));
    end
    tick();
  endtask

  task automatic test_branch_hold();
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 1'b1, 1'b0, '0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h200);
    checks++;
    if (PCE !== 1'b1 || PCin !== 32'h200 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL hold_br got pce=%b pcin=%h req=%b exp 1 00000200 0", PCE, PCin, imem_req);
    end
    tick();
    drive(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL hold_br_after got v=%b instr=%h req=%b addr=%h exp 0 %h 1 00000200", instr_valid, instr_out, imem_req, imem_addr, NOP);
    end
    tick();
  endtask

  task automatic test_wrap_reset();
    do_reset(32'hFFFFFFFC);
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (PCE !== 1'b1 || PCin !== 32'h0) begin
      errors++;
      $display("FAIL wrap got pce=%b pcin=%h exp 1 00000000", PCE, PCin);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    #2;
    R = 1'b1;
    #1;
    model_reset();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_out !== NOP) begin
      errors++;
      $display("FAIL async_rst got req=%b v=%b instr=%h exp 0 0 %h", imem_req, instr_valid, instr_out, NOP);
    end
    @(negedge clock);
    drive(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (PCE !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got pce=%b req=%b exp 0 0", PCE, imem_req);
    end
    tick();
    R = 1'b0;
    in_rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (PCE !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL late_ready got pce=%b req=%b v=%b exp 0 0 0", PCE, imem_req, instr_valid);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (imem_req !== 1'b1 || PCE !== 1'b1 || PCin !== pc + 32'd4 || obs_bus !== exp_bus) begin
      errors++;
      $display("FAIL restart got=%h exp=%h", obs_bus, exp_bus);
    end
    tick();
  endtask

  task automatic test_random();
    bit rdy, st, br;
    logic [31:0] tgt;
    for (int i = 0; i < 3000; i++) begin
      rdy = $urandom_range(0, 9) < 6;
      st  = $urandom_range(0, 9) < 3;
      br  = $urandom_range(0, 19) == 0;
      tgt = $urandom() & 32'hFFFF_FFFC;
      drive(rdy, st, br, tgt);
      checks++;
      if (obs_bus !== exp_bus) begin
        errors++;
        $display("FAIL rand_bus cyc=%0d got=%h exp=%h", i, obs_bus, exp_bus);
      end
      if (exp_valid) begin
        checks++;
        if (PC_4_out !== exp_pc4) begin
          errors++;
          $display("FAIL rand_pc4 cyc=%0d got=%h exp=%h", i, PC_4_out, exp_pc4);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_wait();
    test_stall_hold();
    test_branch_wait();
    test_branch_hold();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
